// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the execution stage and the iterative RV32M unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic            kill_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] dat_a_i;
  logic [XLEN-1:0] dat_b_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, kill_i, funct3_i, dat_a_i, dat_b_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, kill_i, funct3_i, dat_a_i, dat_b_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply, restoring divide,
// one bit per cycle on magnitudes with a final sign fix-up.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk_i,
  input logic          rst_ni,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2:0]        f;
  logic              is_div_in, signed_a_in, signed_b_in, sa, sb;
  logic [XLEN-1:0]   a, b, mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic              accept;

  assign f = bus.funct3_i;
  assign a = bus.dat_a_i;
  assign b = bus.dat_b_i;

  assign is_div_in   = f[2];
  assign signed_a_in = (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
  assign signed_b_in = (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
  assign sa          = signed_a_in & a[XLEN-1];
  assign sb          = signed_b_in & b[XLEN-1];
  assign mag_a       = sa ? -a : a;
  assign mag_b       = sb ? -b : b;

  assign div_zero = is_div_in && (b == '0);
  assign div_ovf  = ((f == 3'b100) || (f == 3'b110)) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // Divide-by-zero yields the RISC-V defined values; overflow yields MIN / 0.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = f[1] ? a : '1;
    else if (div_ovf)
      special_res = f[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  assign accept = (state_q == IDLE) && bus.start_i && !bus.kill_i;

  // One iteration of each algorithm; both share the double-width accumulator.
  logic [XLEN:0]     mul_sum, div_upper, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_upper = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_upper - {1'b0, opd_q};
  assign div_next  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = f;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(XLEN - 1);
            neg_d   = (f == 3'b110) ? sa : (sa ^ sb);
            acc_d   = is_div_in ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opd_d   = is_div_in ? mag_b : mag_a;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0)
          state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    // A flush wins over everything, including a pending result load.
    if (bus.kill_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign bus.stall_o  = accept || (state_q == CALC) || (state_q == FIX);
  assign bus.busy_o   = (state_q == CALC) || (state_q == FIX);
  assign bus.done_o   = (state_q == DONE);
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus per-cycle monitor.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   cyc;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'h0) ||
           (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    int          ai, bi;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ai = a;
    bi = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ai / bi;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ai % bi;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Expected-timeline state shared between the issuing task and the monitor.
  logic        act = 1'b0;
  logic        spec_v = 1'b0;
  int          t0 = 0;
  int          lat_v = 0;
  int          kill_at_v = -1;
  int          rst_at_v = -1;
  logic [31:0] exp_res = '0;
  logic [31:0] last_res = '0;

  always @(negedge clk) begin
    int k;
    k = cyc - t0;
    if (act && rst_at_v >= 0 && k >= rst_at_v) begin
      act      = 1'b0;
      last_res = '0;
    end
    if (act && kill_at_v >= 0 && k > kill_at_v) act = 1'b0;
    if (act) begin
      chk("stall", {31'h0, bus.stall_o}, {31'h0, k < lat_v});
      chk("busy",  {31'h0, bus.busy_o},  {31'h0, !spec_v && k >= 1 && k < lat_v});
      chk("done",  {31'h0, bus.done_o},  {31'h0, k == lat_v});
      chk("result", bus.result_o, (k == lat_v) ? exp_res : last_res);
      if (k == lat_v) begin
        last_res = exp_res;
        act      = 1'b0;
      end
    end else begin
      chk("idle_stall", {31'h0, bus.stall_o}, 32'h0);
      chk("idle_busy",  {31'h0, bus.busy_o},  32'h0);
      chk("idle_done",  {31'h0, bus.done_o},  32'h0);
      chk("idle_result", bus.result_o, last_res);
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic hold, input int kill_at, input int rst_at);
    int k;
    @(posedge clk); #1;
    bus.start_i  = 1'b1;
    bus.funct3_i = f;
    bus.dat_a_i  = a;
    bus.dat_b_i  = b;
    t0        = cyc;
    spec_v    = is_special(f, a, b);
    lat_v     = spec_v ? 1 : 34;
    kill_at_v = kill_at;
    rst_at_v  = rst_at;
    exp_res   = exp;
    act       = 1'b1;
    for (int i = 0; i < 80 && act; i++) begin
      @(posedge clk); #1;
      k = cyc - t0;
      if (!hold) begin
        bus.start_i  = 1'b0;
        bus.funct3_i = 3'($urandom_range(0, 7));
        bus.dat_a_i  = $urandom;
        bus.dat_b_i  = $urandom;
      end
      bus.kill_i = (k == kill_at);
      if (k == rst_at) rst_n = 1'b0;
    end
    if (act) begin
      checks++;
      $display("FAIL timeout: op %0d still pending after bound, expected completion at cycle %0d", f, lat_v);
      act = 1'b0;
    end
    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    if (rst_at >= 0) begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[11] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
    '{3'd5, 32'd100,       32'd7,         32'd14},
    '{3'd7, 32'd100,       32'd7,         32'd2},
    '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,         32'd0,         32'd5},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}
  };

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.kill_i   = 1'b0;
    bus.funct3_i = '0;
    bus.dat_a_i  = '0;
    bus.dat_b_i  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      chk("model", model(vecs[i].f, vecs[i].a, vecs[i].b), vecs[i].r);
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, (i % 2) == 0, -1, -1);
    end

    // Flush mid-multiply: result must keep the last value, then a fresh divide completes.
    issue(3'd0, 32'd1234, 32'd5678, model(3'd0, 32'd1234, 32'd5678), 1'b0, 10, -1);
    issue(3'd5, 32'd9, 32'd3, 32'd3, 1'b0, -1, -1);

    // Reset mid-divide, then a back-to-back operation after release.
    issue(3'd4, 32'hFFFF_FF00, 32'd7, model(3'd4, 32'hFFFF_FF00, 32'd7), 1'b0, -1, 20);
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, -1, -1);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(f, a, b, model(f, a, b), 1'($urandom_range(0, 1)), -1, -1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine beside the execution stage; handles all eight M-extension ops on the integer pipeline's operands.
- Holds the pipeline through stall_o while computing, then presents a one-cycle done_o/result_o pair the execution stage muxes in place of the ALU result.
- kill_i (branch/jump flush, trap) aborts an operation in flight.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  valid M-extension instruction in execution stage
kill_i  input  1  flush; abort current operation
funct3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
dat_a_i  input  XLEN  rs1 operand
dat_b_i  input  XLEN  rs2 operand
stall_o  output  1  hold pipeline; combinational
busy_o  output  1  operation in flight (registered state != IDLE/DONE)
done_o  output  1  result valid, one-cycle pulse
result_o  output  XLEN  result, held until next accepted start

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, counter=0, all internal registers 0, done_o=0, busy_o=0, result_o=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 & kill_i=0: latch funct3_i and operands; go to CALC with counter=XLEN-1.
  - Operands converted to magnitudes per signedness: MULH both signed, MULHSU a signed/b unsigned, DIV/REM signed, others unsigned.
  - Result sign latched: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Special cases (from IDLE, go directly to DONE in one edge; CALC skipped):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dat_a_i.
  - Signed overflow, DIV with a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- CALC:
  - One iteration per cycle.
  - Multiply: 2*XLEN shift-add accumulator.
  - Divide: restoring shift-subtract, 2*XLEN remainder/quotient register.
  - Counter decrements; counter==0 -> FIX.
- FIX (one cycle): two's-complement negation per latched sign; select low word (MUL), high word (MULH/MULHSU/MULHU), quotient or remainder; load result_o; -> DONE.
- DONE: done_o=1 for exactly this cycle; -> IDLE. A start_i in this cycle is ignored (same instruction retiring); the next instruction's start is accepted from IDLE.
- Latency: start seen at cycle 0 -> done_o in cycle XLEN+2 (34) normal, cycle 1 special case.
- stall_o = (IDLE & start_i & !kill_i) | CALC | FIX. Low in DONE so the pipeline advances with result_o.
- kill_i=1 in any state: next state IDLE, no done_o, result_o unchanged. kill_i has priority over start_i.
- result_o changes only on the FIX->DONE or special-case IDLE->DONE load.
- funct3 and operand changes while busy are ignored (latched copies used).
- Reset mid-operation: immediate return to reset values; no done_o.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> stall_o high cycles 0-33, done_o cycle 34, result_o=0xFFFFFFEB.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF with done_o in cycle 1; REM a=5, b=0 -> 5; DIV a=0x80000000, b=-1 -> 0x80000000 in cycle 1.
- Start MUL, assert kill_i in cycle 10 -> IDLE in cycle 11, stall_o=0, no done_o, result_o keeps previous value; new DIVU 9/3 then yields 3.
- Deassert rst_ni in cycle 20 of a DIV -> done_o/busy_o/result_o=0 immediately; after release a back-to-back start completes normally.
